// File: rtl/simon_pkg.sv
// Shared constants, FSM encoding and small helpers for the Simon input path.
package simon_pkg;

    localparam int NUM_BUTTONS            = 4;
    localparam int BTN_IDX_W              = 2;
    localparam int DEBOUNCE_TICKS_DEFAULT = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_LOCK    = 2'd2
    } btn_state_e;

    // Number of set bits in the debounced button vector.
    function automatic logic [2:0] btn_count(input logic [NUM_BUTTONS-1:0] v);
        logic [2:0] n;
        n = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            n = n + {2'b00, v[i]};
        end
        return n;
    endfunction

    // Index of the highest set bit; only meaningful when exactly one bit is set.
    function automatic logic [BTN_IDX_W-1:0] btn_index(input logic [NUM_BUTTONS-1:0] v);
        logic [BTN_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (v[i]) idx = BTN_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/simon_button_input_debounce.sv
// One button: 2-FF synchroniser followed by a stable-count debouncer.
module button_debounce
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_i,
    output logic stable_o
);

    localparam logic [3:0] LAST_CNT = 4'(DEBOUNCE_TICKS - 1);

    logic       meta_q, sync_q;
    logic       stable_q, stable_d;
    logic [3:0] cnt_q, cnt_d;

    // Bring the raw asynchronous button into the clock domain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= btn_i;
            sync_q <= meta_q;
        end
    end

    // A level change is accepted only after DEBOUNCE_TICKS consecutive differing samples.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync_q != stable_q) begin
            if (cnt_q == LAST_CNT) begin
                stable_d = sync_q;
            end else begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;

endmodule

// File: rtl/simon_button_input.sv
// Player-input conditioner: debounced buttons feed a press/chord/lockout FSM.
module simon_button_input
    import simon_pkg::*;
#(
    parameter int DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEFAULT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_BUTTONS-1:0] btn,
    input  logic                   enable,
    output logic [BTN_IDX_W-1:0]   playerNum,
    output logic                   playerPressed,
    output logic                   multiPress
);

    logic [NUM_BUTTONS-1:0] stable;
    logic [2:0]             nset;

    btn_state_e           state_q, state_d;
    logic [BTN_IDX_W-1:0] num_q, num_d;
    logic                 pressed_q, pressed_d;
    logic                 multi_q, multi_d;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        button_debounce #(.DEBOUNCE_TICKS(DEBOUNCE_TICKS)) u_db (
            .clk      (clk),
            .reset    (reset),
            .btn_i    (btn[i]),
            .stable_o (stable[i])
        );
    end

    assign nset = btn_count(stable);

    // Next state and registered-output values; anything held across a turn
    // boundary or chord parks in LOCK until every button is released.
    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pressed_d = 1'b0;
        multi_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (nset == 3'd1) begin
                    if (enable) begin
                        num_d     = btn_index(stable);
                        pressed_d = 1'b1;
                        state_d   = ST_PRESSED;
                    end else begin
                        state_d = ST_LOCK;
                    end
                end else if (nset >= 3'd2) begin
                    multi_d = enable;
                    state_d = ST_LOCK;
                end
            end
            ST_PRESSED: begin
                if (stable[num_q]) begin
                    pressed_d = 1'b1;
                end else begin
                    state_d = (stable != '0) ? ST_LOCK : ST_IDLE;
                end
            end
            ST_LOCK: begin
                if (stable == '0) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            num_q     <= '0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            multi_q   <= multi_d;
        end
    end

    assign playerNum     = num_q;
    assign playerPressed = pressed_q;
    assign multiPress    = multi_q;

endmodule

// File: doc/simon_button_input.md
# simon_button_input

Player-input conditioner for the Simon game; sits directly upstream of the Simon sequencer FSM and produces its `playerNum` / `playerPressed` inputs. It synchronises and debounces four raw push-buttons and rejects chords, bounces and presses made outside the player's turn. Its output is a clean level-type press, with a stable 2-bit button index held for the whole press. The design runs on the same 60 Hz game clock as the sequencer.

## Interface
- `DEBOUNCE_TICKS`, default 3: consecutive stable cycles required to accept a level change (50 ms at 60 Hz); legal range 1..15.
- `clk`  input  1  60 Hz game clock.
- `reset`  input  1  asynchronous, active-high reset.
- `btn`  input  4  raw, asynchronous, active-high buttons; bit i is button index i.
- `enable`  input  1  high when presses may be accepted; driven by `!simonTurn`.
- `playerNum`  output  2  index of the accepted button; held after release.
- `playerPressed`  output  1  high for the whole accepted press.
- `multiPress`  output  1  one-cycle pulse when a chord (more than one button) is rejected.

## Operation
- **Per button, synchronise:** 2-FF synchroniser gives `sync`.
- **Per button, debounce:** `stable` register plus counter, width 4 bits.
  - `sync != stable`: the counter increments.
  - Counter `== DEBOUNCE_TICKS-1` with `sync != stable`: `stable` flips and the counter clears.
  - `sync == stable`: the counter clears. Any bounce restarts the count.
- **Control FSM** runs on the 4-bit `stable` vector. States: IDLE, PRESSED, LOCK.
  - **IDLE:**
    - `enable=1` and exactly one bit of `stable` set: latch its index into `playerNum`, set `playerPressed=1`, go to PRESSED.
    - Two or more bits set, with any `enable`: pulse `multiPress` when `enable=1`, then go to LOCK.
    - Exactly one bit set with `enable=0`: go to LOCK with no pulse.
  - **PRESSED:**
    - `playerNum` is frozen. Other buttons are ignored and `enable` is ignored.
    - When the latched button's `stable` falls: set `playerPressed=0`. Go to LOCK if any other bit is still set, otherwise go to IDLE.
  - **LOCK:** outputs idle. Go to IDLE once `stable == 0`.
- A button held through the player's turn boundary or through a chord must be released before any new press is accepted.

## Timing
- **Reset values:**
  - `playerNum=0`, `playerPressed=0`, `multiPress=0`.
  - State IDLE; all `sync`, `stable` and counter registers are 0.
- **Press latency:** raw edge to `playerPressed` rise is 3+DEBOUNCE_TICKS cycles (6 at default).
  - 2 cycles in the synchroniser.
  - DEBOUNCE_TICKS cycles in the debounce counter.
  - 1 cycle for the registered FSM output.
- **Release latency:** raw release to `playerPressed` fall is the same, 3+DEBOUNCE_TICKS cycles.
- **Minimum accepted pulse:** a raw press shorter than DEBOUNCE_TICKS cycles is never seen.
- **Output registration:** all outputs are registered; `playerNum` is valid on the same edge `playerPressed` rises.
- **Simultaneous debounce completion:**
  - Two buttons completing debounce in the same cycle count as a chord.
  - Two buttons completing on different cycles: the first one wins and the FSM enters PRESSED.
- **Reset mid-press:** outputs clear immediately. A button still held after reset is deasserted re-qualifies as a new press after 3+DEBOUNCE_TICKS cycles, if `enable=1`.
- **`enable` falling while PRESSED:** the press completes normally.

## Structure
- Shared package `simon_pkg`:
  - `NUM_BUTTONS=4`
  - `BTN_IDX_W=2`
  - FSM state encoding `ST_IDLE`/`ST_PRESSED`/`ST_LOCK`
  - default `DEBOUNCE_TICKS`
- Sub-module `button_debounce`: one instance per button. Contains the synchroniser, counter and `stable` register, and is parameterised by DEBOUNCE_TICKS. The top level holds the FSM and the one-hot to index encoder.

## Test plan
All scenarios use DEBOUNCE_TICKS=3.
- **Reset:** assert `reset` asynchronously mid-cycle → all outputs 0 immediately; hold `btn=4'b1000` through reset with `enable=1` → `playerPressed` rises 6 cycles after reset deasserts, `playerNum=3`.
- **Clean press:** `enable=1`, `btn=4'b0100` held 10 cycles then released → `playerPressed` high from raw edge +6 to release +6, `playerNum=2` throughout, `playerNum` still 2 afterwards.
- **Bounce:** `btn[1]` toggles 1,0,1,0,1,0 on successive cycles then stays 0 → `playerPressed` never rises; repeat with toggling then held 1 → rises 6 cycles after the last rising edge.
- **Chord:** `btn=4'b0011` asserted together → `multiPress` high exactly 1 cycle, `playerPressed` stays 0; release `btn[0]` only → nothing happens; release both, then press `btn[0]` → accepted with `playerNum=0`.
- **Gated turn:** `enable=0`, press `btn[3]`, raise `enable` while held → no press; release, press again → accepted with `playerNum=3`.
- **Overlap:** hold `btn[0]` (accepted), then press `btn[2]` → `playerNum` stays 0; release `btn[0]` → `playerPressed` falls; pressing `btn[1]` is ignored until `btn[2]` is released.
